// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared types and constants for the 4-digit seven-segment scan controller.
// Segment byte layout is {dp,g,f,e,d,c,b,a}, active-low.
package seven_seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Index 15 is leftmost; bit 7 (dp) is left dark and supplied by the decoder.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/seven_seg_scan_ctrl_decoder.sv
// Combinational hex-to-segment decoder with decimal point, active-low output.
module seg7_hex_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp,
    output logic [7:0] seg
);

    logic [7:0] table_seg;

    always_comb begin
        table_seg = SEG_TABLE[hex];
        seg       = {~dp, table_seg[6:0]};
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scan controller with per-slot blanking
// and per-frame snapshot. Optional leading-zero suppression: LEADING_ZERO_BLANK_EN.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned SCAN_HZ      = 1000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_digits,
    input  logic [3:0]  i_dp,
    output logic [1:0]  o_sel,
    output logic        o_ena,
    output logic [7:0]  o_seg,
    output logic        o_frame
);

    localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
    localparam int unsigned CNT_W = $clog2(DIV);

    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    generate
        if (BLANK_CYCLES < 2 || BLANK_CYCLES >= DIV) begin : g_bad_params
            $error("seven_seg_scan_ctrl: need 2 <= BLANK_CYCLES < CLK_HZ/SCAN_HZ");
        end
    endgenerate

    scan_state_t      state;
    scan_state_t      state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [1:0]       sel_next;
    logic             ena_next;
    logic [7:0]       seg_next;
    logic             frame_next;
    logic             slot_end;
    logic             wrap;
    logic             load_seg;

    logic [15:0]      snap_digits;
    logic [3:0]       snap_dp;

    logic [3:0]       cur_hex;
    logic             cur_dp;
    logic [7:0]       dec_seg;
    logic [7:0]       pattern;

    always_comb begin
        cur_hex = snap_digits[{o_sel, 2'b00} +: 4];
        cur_dp  = snap_dp[o_sel];
    end

    seg7_hex_decoder u_dec (
        .hex (cur_hex),
        .dp  (cur_dp),
        .seg (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] lz_blank;

    // A digit is suppressed only when it and every digit to its left are zero.
    always_comb begin
        lz_blank[3] = (snap_digits[15:12] == 4'h0);
        lz_blank[2] = lz_blank[3] && (snap_digits[11:8] == 4'h0);
        lz_blank[1] = lz_blank[2] && (snap_digits[7:4] == 4'h0);
        lz_blank[0] = 1'b0;
        pattern     = dec_seg;
        if (lz_blank[o_sel]) begin
            pattern = {dec_seg[7], SEG_OFF[6:0]};
        end
    end
`else
    always_comb begin
        pattern = dec_seg;
    end
`endif

    always_comb begin
        state_next = state;
        slot_end   = (cnt == CNT_LAST);
        cnt_next   = slot_end ? '0 : cnt + 1'b1;
        sel_next   = slot_end ? o_sel + 2'd1 : o_sel;
        wrap       = slot_end && (o_sel == 2'd3);
        load_seg   = (state == BLANK) && (cnt == '0);

        case (state)
            BLANK:   if (cnt == CNT_BLANK_LAST) state_next = DRIVE;
            DRIVE:   if (slot_end)              state_next = BLANK;
            default:                            state_next = BLANK;
        endcase

        ena_next   = (state_next == DRIVE);
        seg_next   = load_seg ? pattern : o_seg;
        frame_next = wrap;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= BLANK;
            cnt         <= '0;
            o_sel       <= '0;
            o_ena       <= 1'b0;
            o_seg       <= SEG_OFF;
            o_frame     <= 1'b0;
            snap_digits <= '0;
            snap_dp     <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            o_sel   <= sel_next;
            o_ena   <= ena_next;
            o_seg   <= seg_next;
            o_frame <= frame_next;
            if (wrap) begin
                snap_digits <= i_digits;
                snap_dp     <= i_dp;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomised and directed bench for seven_seg_scan_ctrl against a timeline model.
module tb_seven_seg_scan_ctrl;

    localparam int unsigned DIV   = 10;
    localparam int unsigned BLANK = 2;
    localparam int unsigned FRAME = 4 * DIV;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [15:0] i_digits = 16'h1234;
    logic [3:0]  i_dp = 4'h0;
    logic [1:0]  o_sel;
    logic        o_ena;
    logic [7:0]  o_seg;
    logic        o_frame;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned t = 0;
    logic [15:0] snap_d[$];
    logic [3:0]  snap_p[$];

    logic [7:0] hex_ref [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seven_seg_scan_ctrl #(
        .CLK_HZ       (40),
        .SCAN_HZ      (4),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_digits (i_digits),
        .i_dp     (i_dp),
        .o_sel    (o_sel),
        .o_ena    (o_ena),
        .o_seg    (o_seg),
        .o_frame  (o_frame)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] ref_seg(input logic [15:0] d, input logic [3:0] p,
                                           input int unsigned s);
        logic [7:0] seg;
        logic [3:0] nib;
        logic       blank;
        nib   = d[4*s +: 4];
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (s > 0) blank = ((d >> (4 * s)) == 16'h0);
`endif
        seg = blank ? 8'hFF : hex_ref[nib];
        if (p[s]) seg[7] = 1'b0;
        return seg;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic chk_all();
        int unsigned pos;
        int unsigned u;
        logic [7:0]  eseg;
        pos = t % DIV;
        if (t == 0) begin
            eseg = 8'hFF;
        end else begin
            u    = (pos == 0) ? t - 1 : t;
            eseg = ref_seg(snap_d[u / FRAME], snap_p[u / FRAME], (u / DIV) % 4);
        end
        chk("sel",   8'(o_sel),   8'((t / DIV) % 4));
        chk("ena",   8'(o_ena),   8'(pos >= BLANK));
        chk("frame", 8'(o_frame), 8'(t > 0 && t % FRAME == 0));
        chk("seg",   o_seg,       eseg);
    endtask

    task automatic reset_model();
        t = 0;
        snap_d.delete();
        snap_p.delete();
        snap_d.push_back(16'h0);
        snap_p.push_back(4'h0);
    endtask

    task automatic step();
        @(posedge i_clk);
        t++;
        if (t % FRAME == 0) begin
            snap_d.push_back(i_digits);
            snap_p.push_back(i_dp);
        end
        @(negedge i_clk);
        chk_all();
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    initial begin
        #2 i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("rst_sel",   8'(o_sel),   8'h00);
        chk("rst_ena",   8'(o_ena),   8'h00);
        chk("rst_seg",   o_seg,       8'hFF);
        chk("rst_frame", 8'(o_frame), 8'h00);
        i_rst = 1'b0;
        reset_model();
        chk_all();

        // Scan order, blanking and 1234 decode across two frames.
        run(90);

        // Tear: change digits while sel=1; effect appears only after the next wrap.
        for (int unsigned i = 0; i < FRAME && (t % FRAME) != 15; i++) step();
        i_digits = 16'hABCD;
        run(70);

        // Decimal point on digit 2.
        i_digits = 16'h8888;
        i_dp     = 4'b0100;
        run(90);

        // Leading zeros (suppressed only when the option is built in).
        i_digits = 16'h0050;
        i_dp     = 4'h0;
        run(90);

        // Random digits and dp, changed at random points inside frames.
        for (int k = 0; k < 10; k++) begin
            i_digits = 16'($urandom) >> (4 * $urandom_range(0, 4));
            i_dp     = 4'($urandom);
            run($urandom_range(5, 60));
        end

        // Asynchronous reset mid-DRIVE at sel=2.
        for (int unsigned i = 0; i < FRAME && (t % FRAME) != 25; i++) step();
        chk("pre_rst_ena", 8'(o_ena), 8'h01);
        i_rst = 1'b1;
        #1;
        chk("arst_sel",   8'(o_sel),   8'h00);
        chk("arst_ena",   8'(o_ena),   8'h00);
        chk("arst_seg",   o_seg,       8'hFF);
        chk("arst_frame", 8'(o_frame), 8'h00);
        @(negedge i_clk);
        i_rst    = 1'b0;
        i_digits = 16'h4321;
        reset_model();
        chk_all();
        run(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
